// File: rtl/seg_disp_capture_pkg.sv
// Shared types and constants for the seven-segment display capture block.
// Optional feature macro: SEG_CAPTURE_HEX_EN (adds A..F decoding).
package seg_disp_capture_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;
  localparam int VAL_W      = 4;
  localparam int BLANK_W    = 1;
  localparam int INV_W      = 1;
  localparam int CNT_W      = 4;

  // Segment patterns, bit6=a ... bit0=g, active-high.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h47;

  // True when exactly one bit of the digit select is set.
  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg_disp_capture_decode.sv
// seg7_decode: combinational seven-segment pattern to digit value decoder.
// Optional feature macro: SEG_CAPTURE_HEX_EN (patterns for A..F are valid).
module seg7_decode
  import seg_disp_capture_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic [VAL_W-1:0]   value,
  output logic [BLANK_W-1:0] blank,
  output logic [INV_W-1:0]   inv
);

  // Map a segment pattern to its value; unknown patterns flag inv with value 0.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    value = '0;
    blank = '0;
    inv   = '0;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_BLANK: blank = 1'b1;
`ifdef SEG_CAPTURE_HEX_EN
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
`endif
      default:   inv = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_disp_capture.sv
// seg_disp_capture: samples a multiplexed 6-digit seven-segment display,
// decodes each digit once its select has settled, and presents complete
// frames through a valid/ready handshake.
// Optional feature macro: SEG_CAPTURE_HEX_EN (hex digits A..F decode as valid).
module seg_disp_capture
  import seg_disp_capture_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS-1:0]       i_seg_enb,
  input  logic [SEG_W-1:0]            i_seg,
  input  logic                        i_seg_dp,
  output logic [NUM_DIGITS*VAL_W-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]       o_dp,
  output logic [NUM_DIGITS-1:0]       o_blank,
  output logic [NUM_DIGITS-1:0]       o_inv,
  output logic                        o_frame_vld,
  input  logic                        i_frame_rdy,
  output logic                        o_ovf,
  output logic                        o_sel_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [NUM_DIGITS-1:0] SEEN_ALL = '1;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]          prev_enb_q;
  logic [NUM_DIGITS-1:0]          seen_q, seen_d;

  // Working slots, one per digit, filled as digits are captured.
  logic [NUM_DIGITS-1:0][VAL_W-1:0] slot_val_q;
  logic [NUM_DIGITS-1:0]            slot_dp_q;
  logic [NUM_DIGITS-1:0]            slot_blank_q;
  logic [NUM_DIGITS-1:0]            slot_inv_q;

  logic [VAL_W-1:0]   dec_val;
  logic [BLANK_W-1:0] dec_blank;
  logic [INV_W-1:0]   dec_inv;

  logic enb_change;
  logic capture;
  logic sel_err_d;
  logic frame_full;
  logic frame_load;
  logic frame_drop;
  logic vld_d;

  seg7_decode u_decode (
    .seg   (i_seg),
    .value (dec_val),
    .blank (dec_blank),
    .inv   (dec_inv)
  );

  assign enb_change = (i_seg_enb != prev_enb_q);

  // Settle FSM: wait for a select change, let it settle, then capture once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    sel_err_d = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (enb_change) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (enb_change) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          if (is_one_hot(i_seg_enb)) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end else begin
            // A blanked select (all zero) is a normal idle gap, not an error.
            sel_err_d = (i_seg_enb != '0);
            state_d   = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (enb_change) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Frame bookkeeping: load into the outputs when free or being consumed,
  // otherwise drop the completed frame and flag overflow.
  always_comb begin
    frame_full = (seen_q == SEEN_ALL);
    frame_load = frame_full && (!o_frame_vld || i_frame_rdy);
    frame_drop = frame_full && o_frame_vld && !i_frame_rdy;
    seen_d     = (frame_full ? '0 : seen_q) | (capture ? i_seg_enb : '0);
    vld_d      = o_frame_vld;
    if (frame_load) begin
      vld_d = 1'b1;
    end else if (o_frame_vld && i_frame_rdy) begin
      vld_d = 1'b0;
    end
  end

  // FSM state, settle counter, select history and seen mask.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_WAIT;
      cnt_q      <= '0;
      prev_enb_q <= '0;
      seen_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_enb_q <= i_seg_enb;
      seen_q     <= seen_d;
    end
  end

  // Working slots: write the decoded sample into the selected digit's slot.
  always_ff @(posedge clk) begin
    // NOTE: the slot array is small and must read as zero after reset, so it
    // is reset like ordinary registers rather than left as uninitialised RAM.
    if (rst) begin
      slot_val_q   <= '0;
      slot_dp_q    <= '0;
      slot_blank_q <= '0;
      slot_inv_q   <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (i_seg_enb[k]) begin
          slot_val_q[k]   <= dec_val;
          slot_dp_q[k]    <= i_seg_dp;
          slot_blank_q[k] <= dec_blank[0];
          slot_inv_q[k]   <= dec_inv[0];
        end
      end
    end
  end

  // Presented frame, handshake valid and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_digits    <= '0;
      o_dp        <= '0;
      o_blank     <= '0;
      o_inv       <= '0;
      o_frame_vld <= 1'b0;
      o_ovf       <= 1'b0;
      o_sel_err   <= 1'b0;
    end else begin
      if (frame_load) begin
        o_digits <= slot_val_q;
        o_dp     <= slot_dp_q;
        o_blank  <= slot_blank_q;
        o_inv    <= slot_inv_q;
      end
      o_frame_vld <= vld_d;
      o_ovf       <= frame_drop;
      o_sel_err   <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_seg_disp_capture.sv
// Directed self-checking bench for seg_disp_capture (SETTLE = 4).
// Expected hex-digit results follow SEG_CAPTURE_HEX_EN when it is defined.
module tb_seg_disp_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_seg_enb;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_blank;
  logic [5:0]  o_inv;
  logic        o_frame_vld;
  logic        i_frame_rdy;
  logic        o_ovf;
  logic        o_sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  seg_disp_capture #(.SETTLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_seg_enb   (i_seg_enb),
    .i_seg       (i_seg),
    .i_seg_dp    (i_seg_dp),
    .o_digits    (o_digits),
    .o_dp        (o_dp),
    .o_blank     (o_blank),
    .o_inv       (o_inv),
    .o_frame_vld (o_frame_vld),
    .i_frame_rdy (i_frame_rdy),
    .o_ovf       (o_ovf),
    .o_sel_err   (o_sel_err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_seg_enb = '0;
    i_seg     = '0;
    i_seg_dp  = 1'b0;
    rst       = 1'b1;
    step(2);
    rst       = 1'b0;
  endtask

  task automatic drive_digit(input int k, input logic [6:0] pat, input logic dp);
    i_seg_enb = 6'(1 << k);
    i_seg     = pat;
    i_seg_dp  = dp;
  endtask

  // Present one digit for 8 cycles (capture occurs on the 5th edge).
  task automatic scan_digit(input int k, input logic [6:0] pat, input logic dp);
    drive_digit(k, pat, dp);
    step(8);
  endtask

  task automatic handshake();
    i_frame_rdy = 1'b1;
    step(1);
    i_frame_rdy = 1'b0;
  endtask

  initial begin
    i_frame_rdy = 1'b0;
    do_reset();

    // Reset state.
    check("rst_digits",  o_digits,    0);
    check("rst_dp",      o_dp,        0);
    check("rst_blank",   o_blank,     0);
    check("rst_inv",     o_inv,       0);
    check("rst_vld",     o_frame_vld, 0);
    check("rst_ovf",     o_ovf,       0);
    check("rst_sel_err", o_sel_err,   0);

    // Basic scan 0..5 with dp on digit 3; check frame latency.
    scan_digit(0, 7'h7E, 1'b0);
    scan_digit(1, 7'h30, 1'b0);
    scan_digit(2, 7'h6D, 1'b0);
    scan_digit(3, 7'h79, 1'b1);
    scan_digit(4, 7'h33, 1'b0);
    drive_digit(5, 7'h5B, 1'b0);
    step(5);
    check("vld_at_capture", o_frame_vld, 0);
    step(1);
    check("vld_after_capture", o_frame_vld, 1);
    check("scan1_digits", o_digits, 24'h543210);
    check("scan1_blank",  o_blank,  0);
    check("scan1_inv",    o_inv,    0);
    check("scan1_dp",     o_dp,     6'b001000);
    step(2);
    handshake();
    check("hs1_vld_drop", o_frame_vld, 0);

    // Illegal two-hot select between captures; seen must survive.
    scan_digit(0, 7'h79, 1'b0);
    scan_digit(1, 7'h33, 1'b0);
    scan_digit(2, 7'h5B, 1'b0);
    i_seg_enb = 6'b000011;
    step(5);
    check("sel_err_pulse", o_sel_err, 1);
    step(1);
    check("sel_err_clear", o_sel_err, 0);
    step(2);
    scan_digit(3, 7'h5F, 1'b0);
    scan_digit(4, 7'h70, 1'b0);
    scan_digit(5, 7'h7F, 1'b0);
    check("sel_frame_vld",    o_frame_vld, 1);
    check("sel_frame_digits", o_digits,    24'h876543);
    handshake();
    check("hs2_vld_drop", o_frame_vld, 0);

    // Overflow: two full scans without ready.
    scan_digit(0, 7'h7B, 1'b0);
    scan_digit(1, 7'h7F, 1'b0);
    scan_digit(2, 7'h70, 1'b0);
    scan_digit(3, 7'h5F, 1'b0);
    scan_digit(4, 7'h5B, 1'b0);
    scan_digit(5, 7'h33, 1'b0);
    check("ovf_first_vld",    o_frame_vld, 1);
    check("ovf_first_digits", o_digits,    24'h456789);
    scan_digit(0, 7'h7E, 1'b0);
    scan_digit(1, 7'h30, 1'b0);
    scan_digit(2, 7'h6D, 1'b0);
    scan_digit(3, 7'h79, 1'b0);
    scan_digit(4, 7'h33, 1'b0);
    drive_digit(5, 7'h5B, 1'b0);
    step(5);
    check("ovf_before", o_ovf, 0);
    step(1);
    check("ovf_pulse",  o_ovf, 1);
    step(1);
    check("ovf_clear",  o_ovf, 0);
    check("ovf_hold_digits", o_digits,    24'h456789);
    check("ovf_hold_vld",    o_frame_vld, 1);
    handshake();
    check("hs3_vld_drop", o_frame_vld, 0);

    // Hex pattern on digit 2, blank on 4, junk on 5.
    scan_digit(0, 7'h7E, 1'b0);
    scan_digit(1, 7'h30, 1'b0);
    scan_digit(2, 7'h77, 1'b0);
    scan_digit(3, 7'h6D, 1'b0);
    scan_digit(4, 7'h00, 1'b0);
    scan_digit(5, 7'h09, 1'b0);
    check("hex_vld",   o_frame_vld, 1);
    check("hex_blank", o_blank,     6'h10);
`ifdef SEG_CAPTURE_HEX_EN
    check("hex_digits", o_digits, 24'h002A10);
    check("hex_inv",    o_inv,    6'h20);
`else
    check("hex_digits", o_digits, 24'h002010);
    check("hex_inv",    o_inv,    6'h24);
`endif
    handshake();
    check("hs4_vld_drop", o_frame_vld, 0);

    // Rapid toggling every 2 cycles must never capture.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        drive_digit(k, 7'h7E, 1'b0);
        step(2);
      end
    end
    i_seg_enb = '0;
    step(8);
    check("toggle_sel_err", o_sel_err, 0);
    for (int k = 0; k < 5; k++) scan_digit(k, 7'h30, 1'b0);
    step(8);
    check("toggle_no_frame", o_frame_vld, 0);

    // Reset mid-frame discards partial captures.
    do_reset();
    scan_digit(0, 7'h7E, 1'b0);
    scan_digit(1, 7'h30, 1'b0);
    scan_digit(2, 7'h6D, 1'b0);
    do_reset();
    scan_digit(3, 7'h79, 1'b0);
    scan_digit(4, 7'h33, 1'b0);
    scan_digit(5, 7'h5B, 1'b0);
    step(4);
    check("rst_partial_no_frame", o_frame_vld, 0);
    scan_digit(0, 7'h7E, 1'b0);
    scan_digit(1, 7'h30, 1'b0);
    scan_digit(2, 7'h6D, 1'b0);
    scan_digit(3, 7'h79, 1'b0);
    scan_digit(4, 7'h33, 1'b0);
    scan_digit(5, 7'h5B, 1'b0);
    check("post_rst_vld",    o_frame_vld, 1);
    check("post_rst_digits", o_digits,    24'h543210);

    // Reset while a frame is pending clears it.
    rst = 1'b1;
    step(1);
    check("rst_pending_vld",    o_frame_vld, 0);
    check("rst_pending_digits", o_digits,    0);
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_disp_capture.md
SEG_DISP_CAPTURE -- requirements
Module: seg_disp_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning cycles a digit select must be stable before its segments are sampled (legal 2..15).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_seg_enb  input  6  digit select, one-hot active-high, bit k = digit k.
REQ-005 SHALL have port i_seg  input  7  segments active-high, bit6=a ... bit0=g.
REQ-006 SHALL have port i_seg_dp  input  1  decimal point of the selected digit.
REQ-007 SHALL have port o_digits  output  24  decoded values, digit k at [4k+3:4k].
REQ-008 SHALL have port o_dp  output  6  captured decimal points.
REQ-009 SHALL have ports o_blank and o_inv  output  6 each  per-digit blank / unrecognised-pattern flags.
REQ-010 SHALL have port o_frame_vld  output  1  a complete frame is presented.
REQ-011 SHALL have port i_frame_rdy  input  1  consumer accepts the frame.
REQ-012 SHALL have ports o_ovf and o_sel_err  output  1 each  one-cycle pulses: frame dropped / illegal select.

Function
REQ-013 SHALL run FSM WAIT, SETTLE, HOLD; WAIT->SETTLE on any i_seg_enb change with the settle counter cleared.
REQ-014 In SETTLE, any i_seg_enb change SHALL clear the counter and stay in SETTLE.
REQ-015 In SETTLE, when the counter reaches SETTLE-1 with i_seg_enb one-hot, it SHALL sample i_seg and i_seg_dp into digit k's working slot, set seen[k], and go to HOLD.
REQ-016 In SETTLE, when the counter reaches SETTLE-1 with i_seg_enb zero or not one-hot, it SHALL return to WAIT with no capture; for not one-hot, it SHALL pulse o_sel_err one cycle.
REQ-017 In HOLD, an i_seg_enb change SHALL go to SETTLE; a re-select of a seen digit SHALL overwrite its slot.
REQ-018 Decode: 7E,30,6D,79,33,5B,5F,70,7F,7B SHALL give 0..9; 00 SHALL give value 0 with blank=1; any other pattern SHALL give value 0 with inv=1.
REQ-019 When seen==6'h3F and o_frame_vld=0, the working slots SHALL be copied to the outputs, o_frame_vld SHALL be set the next cycle, and seen SHALL be cleared.
REQ-020 When seen==6'h3F and o_frame_vld=1 without i_frame_rdy that cycle, the frame SHALL be dropped, seen SHALL be cleared, and o_ovf SHALL pulse.
REQ-021 The outputs SHALL stay stable while o_frame_vld=1; the handshake completes when vld and rdy are both 1, and vld SHALL clear the next cycle unless a new frame loads in that same cycle (then vld stays 1).
REQ-022 Latency: o_frame_vld SHALL rise 1 cycle after the sixth distinct digit is captured.

Reset
REQ-023 While rst=1, the block SHALL enter WAIT and clear the counter, seen, the slots, o_digits, o_dp, o_blank, o_inv, o_frame_vld, o_ovf and o_sel_err to 0.
REQ-024 Reset mid-frame or mid-handshake SHALL discard partial and pending frames; the first frame after reset SHALL need all six digits re-seen.

Configuration
REQ-025 With SEG_CAPTURE_HEX_EN defined, patterns 77,1F,4E,3D,4F,47 SHALL decode to A..F with inv=0; without it, they SHALL give value 0 with inv=1.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the 7-bit segment pattern constants, and the blank/invalid code widths.
REQ-027 A combinational sub-module seg7_decode SHALL take 7 segments in and give 4-bit value, blank and inv out; it SHALL be instantiated once on i_seg.

Verification
REQ-028 After rst, scan digits 0..5 each held 8 cycles with patterns 7E,30,6D,79,33,5B -> o_digits=24'h543210, o_frame_vld=1 on the 1st cycle after the digit-5 capture (REQ-022), o_blank=0, o_inv=0.
REQ-029 Hold i_seg_enb=6'b000011 for 8 cycles -> o_sel_err pulses once and seen is unchanged.
REQ-030 Hold i_frame_rdy=0 and complete two full scans -> o_ovf pulses once and o_digits holds the first frame; then rdy=1 -> vld drops next cycle.
REQ-031 Toggle i_seg_enb every 2 cycles with SETTLE=4 -> no capture and no frame.
REQ-032 Send pattern 77 on digit 2 -> o_inv[2]=0 and value A with SEG_CAPTURE_HEX_EN; o_inv[2]=1 and value 0 without it.
REQ-033 Assert rst after 3 digits are captured, then scan 3 more -> no frame; a full 6-digit scan -> frame.
